// File: rtl/pc_sequencer_if.sv
// Bus between the decoder/branch logic, the PC register and the PC sequencer.
// The master drives the decoded instruction information and the current PC.
// The slave (the sequencer) returns the PC load controls, the I/O strobes and its status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_current;
  logic              halt_instr;
  logic              input_flag;
  logic              output_flag;
  logic              insert;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              pc_write;
  logic [ADDR_W-1:0] pc_next;
  logic              in_latch_en;
  logic              out_latch_en;
  logic [1:0]        state;
  logic [31:0]       instr_count;

  modport master (
    output pc_current, halt_instr, input_flag, output_flag, insert,
           jump, jump_target, branch_taken, branch_target,
    input  pc_write, pc_next, in_latch_en, out_latch_en, state, instr_count
  );

  modport slave (
    input  pc_current, halt_instr, input_flag, output_flag, insert,
           jump, jump_target, branch_taken, branch_target,
    output pc_write, pc_next, in_latch_en, out_latch_en, state, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: decides each cycle whether the PC register loads and what it loads.
// IN instructions stall until a fresh rising edge of the operator insert key.
// OUT instructions stall for a fixed display time.
// HALT stalls until reset.
// The PC controls and the strobes are combinational from the state and the inputs.
// The state and the retired-instruction counter are registered.
module pc_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int OUT_HOLD = 4,
  parameter int STEP     = 4
) (
  input logic              CLK,
  input logic              reset,
  pc_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  seq_state_t        state_r;
  logic [7:0]        hold_r;
  logic              ins_q_r;
  logic [31:0]       instr_count_r;

  logic [ADDR_W-1:0] seq_pc_s;
  logic              ins_rise_s;
  logic              pc_write_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic              in_latch_s;
  logic              out_latch_s;

  // Sequential address wraps naturally at the address width.
  assign seq_pc_s   = bus.pc_current + ADDR_W'(STEP);
  assign ins_rise_s = bus.insert & ~ins_q_r;

  // Combinational PC load decision and I/O strobes for the current state.
  always_comb begin
    pc_write_s  = 1'b0;
    pc_next_s   = seq_pc_s;
    in_latch_s  = 1'b0;
    out_latch_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.halt_instr) begin
          pc_write_s = 1'b0;
        end else if (bus.input_flag) begin
          pc_write_s = 1'b0;
        end else if (bus.output_flag) begin
          out_latch_s = 1'b1;
        end else if (bus.jump) begin
          pc_write_s = 1'b1;
          pc_next_s  = bus.jump_target;
        end else if (bus.branch_taken) begin
          pc_write_s = 1'b1;
          pc_next_s  = bus.branch_target;
        end else begin
          pc_write_s = 1'b1;
        end
      end
      WAIT_IN: begin
        if (ins_rise_s) begin
          pc_write_s = 1'b1;
          in_latch_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      WAIT_OUT: begin
        if (hold_r == 8'd0) begin
          pc_write_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      HALT: begin
        pc_write_s = 1'b0;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // State machine, display hold counter, insert edge register and retired-instruction counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r       <= RUN;
      hold_r        <= 8'd0;
      ins_q_r       <= 1'b0;
      instr_count_r <= 32'd0;
    end else begin
      ins_q_r <= bus.insert;
      if (pc_write_s) begin
        instr_count_r <= instr_count_r + 32'd1;
      end
      case (state_r)
        RUN: begin
          if (bus.halt_instr) begin
            state_r <= HALT;
          end else if (bus.input_flag) begin
            state_r <= WAIT_IN;
          end else if (bus.output_flag) begin
            hold_r  <= 8'(OUT_HOLD - 1);
            state_r <= WAIT_OUT;
          end else begin
            state_r <= RUN;
          end
        end
        WAIT_IN: begin
          if (ins_rise_s) begin
            state_r <= RUN;
          end
        end
        WAIT_OUT: begin
          if (hold_r == 8'd0) begin
            state_r <= RUN;
          end else begin
            hold_r <= hold_r - 8'd1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.pc_next      = pc_next_s;
  assign bus.in_latch_en  = in_latch_s;
  assign bus.out_latch_en = out_latch_s;
  assign bus.state        = state_r;
  assign bus.instr_count  = instr_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer.
// A cycle-level reference model follows the mode of the sequencer: running, waiting for a key,
// displaying until a release cycle, or halted.
// Directed scenarios pin literal values, and a randomized phase exercises flag and insert mixes.
module tb_pc_sequencer;
  localparam int ADDR_W   = 32;
  localparam int OUT_HOLD = 4;
  localparam int STEP     = 4;

  logic CLK;
  logic reset;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) sif ();

  pc_sequencer #(.ADDR_W(ADDR_W), .OUT_HOLD(OUT_HOLD), .STEP(STEP)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (sif.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: mode 0 running, 1 waiting for a fresh key press, 2 displaying, 3 halted.
  int          m_mode    = 0;
  int          m_cyc     = 0;
  int          m_release = 0;
  bit          m_prev_ins = 1'b0;
  logic [31:0] m_count   = 32'd0;

  // Per-cycle comparison against the model; sampled mid-cycle when inputs are stable.
  initial begin : compare_proc
    logic        e_pw, e_in, e_out;
    logic [31:0] e_next, seq;
    int          nmode;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        m_mode = 0; m_count = 32'd0; m_prev_ins = 1'b0;
      end
      seq = sif.pc_current + 32'd4;
      e_pw = 1'b0; e_in = 1'b0; e_out = 1'b0; e_next = seq; nmode = m_mode;
      case (m_mode)
        0: begin
          if (sif.halt_instr) nmode = 3;
          else if (sif.input_flag) nmode = 1;
          else if (sif.output_flag) begin e_out = 1'b1; nmode = 2; m_release = m_cyc + OUT_HOLD; end
          else if (sif.jump) begin e_pw = 1'b1; e_next = sif.jump_target; end
          else if (sif.branch_taken) begin e_pw = 1'b1; e_next = sif.branch_target; end
          else e_pw = 1'b1;
        end
        1: if (sif.insert && !m_prev_ins) begin e_pw = 1'b1; e_in = 1'b1; nmode = 0; end
        2: if (m_cyc == m_release) begin e_pw = 1'b1; nmode = 0; end
        default: nmode = 3;
      endcase
      if (chk_en) begin
        check("state", {30'd0, sif.state}, m_mode);
        check("pc_write", {31'd0, sif.pc_write}, {31'd0, e_pw});
        check("pc_next", sif.pc_next, e_next);
        check("in_latch_en", {31'd0, sif.in_latch_en}, {31'd0, e_in});
        check("out_latch_en", {31'd0, sif.out_latch_en}, {31'd0, e_out});
        check("instr_count", sif.instr_count, m_count);
      end
      if (reset) begin
        m_mode = nmode;
        m_count = m_count + {31'd0, e_pw};
        m_prev_ins = sif.insert;
        m_cyc++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clear_flags();
    sif.halt_instr = 1'b0; sif.input_flag = 1'b0; sif.output_flag = 1'b0;
    sif.jump = 1'b0; sif.branch_taken = 1'b0;
  endtask

  initial begin : stim
    reset = 1'b0;
    clear_flags();
    sif.insert = 1'b0;
    sif.pc_current = 32'h0;
    sif.jump_target = 32'h0;
    sif.branch_target = 32'h0;
    chk_en = 1'b1;
    tick(2);
    check("reset_state", {30'd0, sif.state}, 32'd0);
    check("reset_count", sif.instr_count, 32'd0);

    // Sequential run from 0x10.
    reset = 1'b1;
    sif.pc_current = 32'h10;
    #1;
    check("run_pw", {31'd0, sif.pc_write}, 32'd1);
    check("run_next", sif.pc_next, 32'h14);
    tick(3);
    check("run_count3", sif.instr_count, 32'd3);

    // IN with insert already high on entry.
    sif.pc_current = 32'h20; sif.input_flag = 1'b1; sif.insert = 1'b1;
    #1;
    check("in_enter_pw", {31'd0, sif.pc_write}, 32'd0);
    tick(1);
    sif.input_flag = 1'b0;
    #1;
    check("in_held_state", {30'd0, sif.state}, 32'd1);
    check("in_held_pw", {31'd0, sif.pc_write}, 32'd0);
    tick(2);
    sif.insert = 1'b0;
    tick(5);
    check("in_low_pw", {31'd0, sif.pc_write}, 32'd0);
    sif.insert = 1'b1;
    #1;
    check("in_rel_latch", {31'd0, sif.in_latch_en}, 32'd1);
    check("in_rel_pw", {31'd0, sif.pc_write}, 32'd1);
    check("in_rel_next", sif.pc_next, 32'h24);
    tick(1);
    sif.insert = 1'b0;
    #1;
    check("in_back_run", {30'd0, sif.state}, 32'd0);

    // OUT with a hold of four cycles and an insert pulse during the hold.
    sif.pc_current = 32'h40; sif.output_flag = 1'b1;
    #1;
    check("out_c0_latch", {31'd0, sif.out_latch_en}, 32'd1);
    check("out_c0_pw", {31'd0, sif.pc_write}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick(1);
      sif.output_flag = 1'b0;
      sif.insert = (c == 2) ? 1'b1 : 1'b0;
      #1;
      check("out_hold_pw", {31'd0, sif.pc_write}, 32'd0);
    end
    tick(1);
    #1;
    check("out_c4_pw", {31'd0, sif.pc_write}, 32'd1);
    check("out_c4_next", sif.pc_next, 32'h44);
    tick(1);

    // Jump beats branch; input_flag beats jump.
    sif.jump = 1'b1; sif.jump_target = 32'h100;
    sif.branch_taken = 1'b1; sif.branch_target = 32'h200;
    #1;
    check("jump_prio", sif.pc_next, 32'h100);
    tick(1);
    sif.input_flag = 1'b1;
    #1;
    check("jump_in_pw", {31'd0, sif.pc_write}, 32'd0);
    tick(1);
    clear_flags();
    #1;
    check("jump_in_state", {30'd0, sif.state}, 32'd1);
    sif.insert = 1'b1;
    #1;
    check("jump_in_seq", sif.pc_next, 32'h44);
    tick(1);
    sif.insert = 1'b0;

    // Address wrap.
    sif.pc_current = 32'hFFFF_FFFC;
    #1;
    check("wrap_next", sif.pc_next, 32'h0);
    tick(1);

    // Reset in the middle of an OUT hold with two cycles left.
    sif.output_flag = 1'b1;
    tick(1);
    sif.output_flag = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    check("rst_mid_state", {30'd0, sif.state}, 32'd0);
    check("rst_mid_count", sif.instr_count, 32'd0);
    check("rst_mid_pw", {31'd0, sif.pc_write}, 32'd1);
    check("rst_mid_out", {31'd0, sif.out_latch_en}, 32'd0);
    tick(1);
    reset = 1'b1;

    // HALT holds against any stimulus.
    sif.halt_instr = 1'b1;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      sif.insert = 1'($urandom_range(0, 1));
      sif.input_flag = 1'($urandom_range(0, 1));
      sif.output_flag = 1'($urandom_range(0, 1));
      sif.jump = 1'($urandom_range(0, 1));
      sif.halt_instr = 1'($urandom_range(0, 1));
      #1;
      check("halt_state", {30'd0, sif.state}, 32'd3);
      check("halt_pw", {31'd0, sif.pc_write}, 32'd0);
      tick(1);
    end
    reset = 1'b0;
    clear_flags();
    tick(1);
    reset = 1'b1;

    // Randomized mix of flags, keys, targets and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      sif.pc_current    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      sif.jump_target   = $urandom();
      sif.branch_target = $urandom();
      sif.halt_instr    = ($urandom_range(0, 99) == 0);
      sif.input_flag    = ($urandom_range(0, 9) == 0);
      sif.output_flag   = ($urandom_range(0, 9) == 0);
      sif.jump          = ($urandom_range(0, 5) == 0);
      sif.branch_taken  = ($urandom_range(0, 4) == 0);
      sif.insert        = ($urandom_range(0, 3) == 0);
      reset             = ($urandom_range(0, 79) != 0);
      tick(1);
    end
    reset = 1'b1;
    tick(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
